// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM states, odd-parity helper, command bytes.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        SHIFT,
        ACK,
        WAIT_IDLE
    } state_t;

    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] RSP_ACK      = 8'hFA;

    // Parity bit that makes the total number of ones in data+parity odd.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_cmd_tx_if.sv
// Command-byte handshake into the PS/2 host transmitter.
// Latency: n/a (signal bundle only).
// Backpressure: cmd_ready low while a transfer is in flight; offers are dropped, not queued.
// Signals: cmd_valid (byte offered), cmd_data (command byte), cmd_ready (transmitter idle).
interface ps2_cmd_tx_if;
    import ps2_pkg::*;

    logic       cmd_valid;
    logic [7:0] cmd_data;
    logic       cmd_ready;

    modport master (output cmd_valid, output cmd_data, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_data, output cmd_ready);

endinterface

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for the PS/2 clock and data lines plus a falling-edge strobe on clock.
// Latency: line level 2 cycles; fall strobe 3 cycles after the raw falling edge.
// Backpressure: none; free-running.
// Ports: clk, reset (sync, active-high), clk_raw/dat_raw (async lines),
//        clk_sync/dat_sync (synchronized levels), fall (1-cycle strobe).
module ps2_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic clk_raw,
    input  logic dat_raw,
    output logic clk_sync,
    output logic dat_sync,
    output logic fall
);
    logic [1:0] clk_ff;
    logic [1:0] dat_ff;
    logic       clk_prev;

    // Reset to the idle-high line level so leaving reset never fakes a falling edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_ff   <= 2'b11;
            dat_ff   <= 2'b11;
            clk_prev <= 1'b1;
            fall     <= 1'b0;
        end else begin
            clk_ff   <= {clk_ff[0], clk_raw};
            dat_ff   <= {dat_ff[0], dat_raw};
            clk_prev <= clk_ff[1];
            fall     <= clk_prev & ~clk_ff[1];
        end
    end

    assign clk_sync = clk_ff[1];
    assign dat_sync = dat_ff[1];

endmodule

// File: rtl/ps2_cmd_tx.sv
// PS/2 host-to-device transmitter: inhibit, start bit, 8 data bits LSB first, odd parity, stop, ACK check.
// Latency: clk_oe 1 cycle after accept; each data update 4 cycles after the raw device clock fall.
// Backpressure: cmd_ready only in IDLE; offers while busy are ignored. done/error are 1-cycle pulses.
// Ports: clk, reset (sync, active-high), cmd (command handshake), ps2_clk_in/ps2_dat_in (raw lines),
//        ps2_clk_oe/ps2_dat_oe (1 = pull line low), busy, done, error.
module ps2_cmd_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic         clk,
    input  logic         reset,
    ps2_cmd_tx_if.slave  cmd,
    input  logic         ps2_clk_in,
    input  logic         ps2_dat_in,
    output logic         ps2_clk_oe,
    output logic         ps2_dat_oe,
    output logic         busy,
    output logic         done,
    output logic         error
);
    localparam int INH_W = $clog2(INHIBIT_CYCLES) + 1;
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [INH_W-1:0] INH_END  = INH_W'(INHIBIT_CYCLES);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

    state_t           state, state_nxt;
    logic [9:0]       shreg, shreg_nxt;      // {stop, parity, D7..D0}, shifted out from bit 0
    logic [3:0]       bit_cnt, bit_cnt_nxt;
    logic [INH_W-1:0] inh_cnt, inh_cnt_nxt;
    logic [WD_W-1:0]  wd_cnt, wd_cnt_nxt;
    logic             clk_oe_nxt, dat_oe_nxt, done_nxt, error_nxt;
    logic             clk_sync, dat_sync, fall;
    logic             wd_expired;

    ps2_line_sync u_sync (
        .clk      (clk),
        .reset    (reset),
        .clk_raw  (ps2_clk_in),
        .dat_raw  (ps2_dat_in),
        .clk_sync (clk_sync),
        .dat_sync (dat_sync),
        .fall     (fall)
    );

    // A fall in the same cycle counts as activity, so it wins over the timeout.
    assign wd_expired = (state == SHIFT || state == ACK || state == WAIT_IDLE)
                        && !fall && (wd_cnt == WD_LAST);

    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        bit_cnt_nxt = bit_cnt;
        inh_cnt_nxt = inh_cnt;
        wd_cnt_nxt  = wd_cnt;
        clk_oe_nxt  = ps2_clk_oe;
        dat_oe_nxt  = ps2_dat_oe;
        done_nxt    = 1'b0;
        error_nxt   = 1'b0;

        case (state)
            IDLE: begin
                clk_oe_nxt = 1'b0;
                dat_oe_nxt = 1'b0;
                if (cmd.cmd_valid && cmd.cmd_ready) begin
                    shreg_nxt   = {1'b1, odd_parity(cmd.cmd_data), cmd.cmd_data};
                    bit_cnt_nxt = '0;
                    inh_cnt_nxt = '0;
                    clk_oe_nxt  = 1'b1;
                    state_nxt   = INHIBIT;
                end
            end
            INHIBIT: begin
                inh_cnt_nxt = inh_cnt + INH_W'(1);
                if (inh_cnt == INH_LAST) begin
                    dat_oe_nxt = 1'b1;           // start bit, clock still held low
                end
                if (inh_cnt == INH_END) begin
                    inh_cnt_nxt = '0;
                    clk_oe_nxt  = 1'b0;
                    wd_cnt_nxt  = '0;
                    state_nxt   = SHIFT;
                end
            end
            SHIFT: begin
                wd_cnt_nxt = fall ? '0 : wd_cnt + WD_W'(1);
                if (fall) begin
                    // Falls 1..8 data, 9 parity, 10 stop (a one, so the line is released).
                    dat_oe_nxt  = ~shreg[0];
                    shreg_nxt   = {1'b1, shreg[9:1]};
                    bit_cnt_nxt = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd9) begin
                        state_nxt = ACK;
                    end
                end
            end
            ACK: begin
                wd_cnt_nxt = fall ? '0 : wd_cnt + WD_W'(1);
                if (fall) begin
                    bit_cnt_nxt = bit_cnt + 4'd1;
                    if (dat_sync) begin
                        error_nxt = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                wd_cnt_nxt = fall ? '0 : wd_cnt + WD_W'(1);
                if (clk_sync && dat_sync) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                clk_oe_nxt = 1'b0;
                dat_oe_nxt = 1'b0;
                state_nxt  = IDLE;
            end
        endcase

        if (wd_expired) begin
            clk_oe_nxt = 1'b0;
            dat_oe_nxt = 1'b0;
            done_nxt   = 1'b0;
            error_nxt  = 1'b1;
            state_nxt  = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            shreg         <= '0;
            bit_cnt       <= '0;
            inh_cnt       <= '0;
            wd_cnt        <= '0;
            ps2_clk_oe    <= 1'b0;
            ps2_dat_oe    <= 1'b0;
            cmd.cmd_ready <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
        end else begin
            state         <= state_nxt;
            shreg         <= shreg_nxt;
            bit_cnt       <= bit_cnt_nxt;
            inh_cnt       <= inh_cnt_nxt;
            wd_cnt        <= wd_cnt_nxt;
            ps2_clk_oe    <= clk_oe_nxt;
            ps2_dat_oe    <= dat_oe_nxt;
            cmd.cmd_ready <= (state_nxt == IDLE);
            busy          <= (state_nxt != IDLE);
            done          <= done_nxt;
            error         <= error_nxt;
        end
    end

endmodule
